wash_phase_timer: RTL and testbench

//   Timing stage directly downstream of the washer controller FSM. Consumes the controller's
//   one-hot phase outputs (soak/wash/rinse/spin) and water_Intake; times each phase and

---
 rtl/wash_phase_timer.sv | 170 +++++++++++++++++
 tb/tb_wash_phase_timer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_phase_timer.sv
// Times each washer phase requested by the controller, returns a one-cycle phase_Done,
// and raises a sticky timer_Fault on fill timeout or an illegal phase encoding.
module wash_phase_timer #(
    parameter int PRESCALE     = 1000,
    parameter int SOAK_TICKS   = 30,
    parameter int WASH_TICKS   = 60,
    parameter int RINSE_TICKS  = 40,
    parameter int SPIN_TICKS   = 20,
    parameter int FILL_TIMEOUT = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             soak_Operation,
    input  logic             wash_Operation,
    input  logic             rinse_Operation,
    input  logic             spin_Operation,
    input  logic             water_Intake,
    input  logic             fill_Water,
    input  logic             lid,
    output logic             phase_Done,
    output logic [CNT_W-1:0] remaining,
    output logic             timer_Fault
);

    localparam int PRE_W  = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int FILL_W = $clog2(FILL_TIMEOUT + 1);

    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FILL_TIMEOUT);
    localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

    typedef enum logic [2:0] {
        PH_NONE,
        PH_SOAK,
        PH_WASH,
        PH_RINSE,
        PH_SPIN,
        PH_ILLEGAL
    } phase_t;

    phase_t            decoded_phase;
    phase_t            phase_q, phase_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [CNT_W-1:0]  remaining_d;
    logic [CNT_W-1:0]  load_ticks;
    logic              done_d;
    logic              fault_d;

    logic              armed, armed_q;
    logic [PRE_W-1:0]  fill_pre_q, fill_pre_d;
    logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
    logic              fill_expired;
    logic              paused;
    logic              all_idle;

    always_comb begin
        decoded_phase = PH_ILLEGAL;
        unique case ({soak_Operation, wash_Operation, rinse_Operation, spin_Operation})
            4'b0000: decoded_phase = PH_NONE;
            4'b1000: decoded_phase = PH_SOAK;
            4'b0100: decoded_phase = PH_WASH;
            4'b0010: decoded_phase = PH_RINSE;
            4'b0001: decoded_phase = PH_SPIN;
            default: decoded_phase = PH_ILLEGAL;
        endcase
    end

    always_comb begin
        load_ticks = '0;
        case (decoded_phase)
            PH_SOAK:  load_ticks = CNT_W'(SOAK_TICKS);
            PH_WASH:  load_ticks = CNT_W'(WASH_TICKS);
            PH_RINSE: load_ticks = CNT_W'(RINSE_TICKS);
            PH_SPIN:  load_ticks = CNT_W'(SPIN_TICKS);
            default:  load_ticks = '0;
        endcase
    end

    // While counting, decoded equals stored phase, so spin_Operation here implies the spin phase.
    assign paused   = spin_Operation & lid;
    assign all_idle = ~(soak_Operation | wash_Operation | rinse_Operation |
                        spin_Operation | water_Intake);
    assign armed    = water_Intake & ~fill_Water;

    always_comb begin
        phase_d     = phase_q;
        pre_d       = pre_q;
        remaining_d = remaining;
        done_d      = 1'b0;
        case (decoded_phase)
            PH_NONE: begin
                phase_d     = PH_NONE;
                pre_d       = '0;
                remaining_d = '0;
            end
            PH_ILLEGAL: begin
                phase_d     = phase_q;
            end
            default: begin
                if (decoded_phase != phase_q) begin
                    phase_d     = decoded_phase;
                    pre_d       = '0;
                    remaining_d = load_ticks;
                end else if ((remaining != '0) && !paused) begin
                    if (pre_q == PRE_MAX) begin
                        pre_d       = '0;
                        remaining_d = remaining - CNT_ONE;
                        done_d      = (remaining == CNT_ONE);
                    end else begin
                        pre_d = pre_q + PRE_ONE;
                    end
                end
            end
        endcase
    end

    // The arming edge itself starts the watchdog at zero, mirroring a phase entry edge.
    always_comb begin
        fill_pre_d = fill_pre_q;
        fill_cnt_d = fill_cnt_q;
        if (!armed || !armed_q) begin
            fill_pre_d = '0;
            fill_cnt_d = '0;
        end else if (fill_pre_q == PRE_MAX) begin
            fill_pre_d = '0;
            if (fill_cnt_q != FILL_MAX) begin
                fill_cnt_d = fill_cnt_q + FILL_ONE;
            end
        end else begin
            fill_pre_d = fill_pre_q + PRE_ONE;
        end
    end

    assign fill_expired = (fill_cnt_d == FILL_MAX);

    always_comb begin
        fault_d = timer_Fault;
        if (all_idle) begin
            fault_d = 1'b0;
        end else if ((decoded_phase == PH_ILLEGAL) || fill_expired) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= PH_NONE;
            pre_q       <= '0;
            remaining   <= '0;
            phase_Done  <= 1'b0;
            timer_Fault <= 1'b0;
            armed_q     <= 1'b0;
            fill_pre_q  <= '0;
            fill_cnt_q  <= '0;
        end else begin
            phase_q     <= phase_d;
            pre_q       <= pre_d;
            remaining   <= remaining_d;
            phase_Done  <= done_d;
            timer_Fault <= fault_d;
            armed_q     <= armed;
            fill_pre_q  <= fill_pre_d;
            fill_cnt_q  <= fill_cnt_d;
        end
    end

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer with PRESCALE=4, WASH=3, SPIN=2, FILL_TIMEOUT=2.
module tb_wash_phase_timer;

    localparam int PRESCALE     = 4;
    localparam int SOAK_TICKS   = 2;
    localparam int WASH_TICKS   = 3;
    localparam int RINSE_TICKS  = 2;
    localparam int SPIN_TICKS   = 2;
    localparam int FILL_TIMEOUT = 2;
    localparam int CNT_W        = 8;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             soak_op, wash_op, rinse_op, spin_op;
    logic             water_intake, fill_water, lid;
    logic             phase_done;
    logic [CNT_W-1:0] remaining;
    logic             timer_fault;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    wash_phase_timer #(
        .PRESCALE(PRESCALE), .SOAK_TICKS(SOAK_TICKS), .WASH_TICKS(WASH_TICKS),
        .RINSE_TICKS(RINSE_TICKS), .SPIN_TICKS(SPIN_TICKS),
        .FILL_TIMEOUT(FILL_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .soak_Operation(soak_op), .wash_Operation(wash_op),
        .rinse_Operation(rinse_op), .spin_Operation(spin_op),
        .water_Intake(water_intake), .fill_Water(fill_water), .lid(lid),
        .phase_Done(phase_done), .remaining(remaining), .timer_Fault(timer_fault)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic go_idle();
        {soak_op, wash_op, rinse_op, spin_op, water_intake, fill_water, lid} = '0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        {soak_op, wash_op, rinse_op, spin_op, water_intake, fill_water, lid} = '0;
        #12;
        vectors++;
        if (phase_done !== 1'b0 || remaining !== 8'd0 || timer_fault !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got done=%b rem=%0d fault=%b exp 0/0/0",
                     phase_done, remaining, timer_fault);
        end
        @(posedge clock);
        #1 reset_n = 1'b1;
        step();
        vectors++;
        if (phase_done !== 1'b0 || remaining !== 8'd0 || timer_fault !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL post_reset got done=%b rem=%0d fault=%b exp 0/0/0",
                     phase_done, remaining, timer_fault);
        end
    endtask

    // Lid is held open throughout: it must not stall a non-spin phase.
    task automatic test_wash();
        logic [CNT_W-1:0] exp_rem;
        wash_op = 1'b1;
        lid     = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            step();
            exp_rem = (k >= 12) ? 8'd0 : 8'(3 - k / 4);
            vectors++;
            if (remaining !== exp_rem) begin
                miscompares++;
                $display("[TB] FAIL wash_rem E%0d got=%0d exp=%0d", k, remaining, exp_rem);
            end
            vectors++;
            if (phase_done !== (k == 12)) begin
                miscompares++;
                $display("[TB] FAIL wash_done E%0d got=%b exp=%b", k, phase_done, (k == 12));
            end
        end
        go_idle();
    endtask

    task automatic test_pause();
        logic [CNT_W-1:0] exp_rem;
        spin_op = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            step();
            exp_rem = (k >= 13) ? 8'd0 : ((k >= 9) ? 8'd1 : 8'd2);
            vectors++;
            if (remaining !== exp_rem) begin
                miscompares++;
                $display("[TB] FAIL pause_rem E%0d got=%0d exp=%0d", k, remaining, exp_rem);
            end
            vectors++;
            if (phase_done !== (k == 13)) begin
                miscompares++;
                $display("[TB] FAIL pause_done E%0d got=%b exp=%b", k, phase_done, (k == 13));
            end
            if (k == 2) lid = 1'b1;
            if (k == 7) lid = 1'b0;
        end
        go_idle();
    endtask

    task automatic test_switch();
        logic [CNT_W-1:0] exp_rem;
        wash_op = 1'b1;
        for (int k = 0; k <= 8; k++) step();
        vectors++;
        if (remaining !== 8'd1) begin
            miscompares++;
            $display("[TB] FAIL switch_pre_rem got=%0d exp=1", remaining);
        end
        wash_op = 1'b0;
        spin_op = 1'b1;
        for (int k = 9; k <= 18; k++) begin
            step();
            exp_rem = (k >= 17) ? 8'd0 : ((k >= 13) ? 8'd1 : 8'd2);
            vectors++;
            if (remaining !== exp_rem) begin
                miscompares++;
                $display("[TB] FAIL switch_rem E%0d got=%0d exp=%0d", k, remaining, exp_rem);
            end
            vectors++;
            if (phase_done !== (k == 17)) begin
                miscompares++;
                $display("[TB] FAIL switch_done E%0d got=%b exp=%b", k, phase_done, (k == 17));
            end
        end
        vectors++;
        if (timer_fault !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL switch_fault got=%b exp=0", timer_fault);
        end
        go_idle();
    endtask

    task automatic test_fill();
        water_intake = 1'b1;
        fill_water   = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            step();
            vectors++;
            if (timer_fault !== (k >= 8)) begin
                miscompares++;
                $display("[TB] FAIL fill_timeout A%0d got=%b exp=%b", k, timer_fault, (k >= 8));
            end
        end
        water_intake = 1'b0;
        step();
        vectors++;
        if (timer_fault !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fault_clear got=%b exp=0", timer_fault);
        end
        water_intake = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            step();
            vectors++;
            if (timer_fault !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL fill_ok A%0d got=%b exp=0", k, timer_fault);
            end
            if (k == 6) fill_water = 1'b1;
        end
        go_idle();
    endtask

    task automatic test_illegal();
        wash_op  = 1'b1;
        rinse_op = 1'b1;
        step();
        vectors++;
        if (timer_fault !== 1'b1 || remaining !== 8'd0 || phase_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL illegal_edge got fault=%b rem=%0d done=%b exp 1/0/0",
                     timer_fault, remaining, phase_done);
        end
        rinse_op = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            vectors++;
            if (timer_fault !== 1'b1 || remaining !== 8'd3) begin
                miscompares++;
                $display("[TB] FAIL illegal_sticky E%0d got fault=%b rem=%0d exp 1/3",
                         k, timer_fault, remaining);
            end
        end
        wash_op = 1'b0;
        step();
        vectors++;
        if (timer_fault !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL illegal_clear got=%b exp=0", timer_fault);
        end
        go_idle();
    endtask

    // An illegal edge mid-wash holds the counters, then reset aborts the phase.
    task automatic test_reset_mid();
        wash_op = 1'b1;
        for (int k = 0; k <= 5; k++) step();
        soak_op = 1'b1;
        step();
        soak_op = 1'b0;
        step();
        vectors++;
        if (remaining !== 8'd2 || timer_fault !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL hold_E7 got rem=%0d fault=%b exp 2/1", remaining, timer_fault);
        end
        step();
        vectors++;
        if (remaining !== 8'd2) begin
            miscompares++;
            $display("[TB] FAIL hold_E8 got rem=%0d exp=2", remaining);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (phase_done !== 1'b0 || remaining !== 8'd0 || timer_fault !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_async got done=%b rem=%0d fault=%b exp 0/0/0",
                     phase_done, remaining, timer_fault);
        end
        wash_op = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            vectors++;
            if (phase_done !== 1'b0 || remaining !== 8'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_abort C%0d got done=%b rem=%0d exp 0/0",
                         k, phase_done, remaining);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wash();
        test_pause();
        test_switch();
        test_fill();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
